// File: rtl/ysyx_23060025_wbuf_pkg.sv
// Shared AXI/write-buffer encodings and the write-buffer FSM state constants.
`ifndef YSYX_23060025_WBUF_DEFINES
`define YSYX_23060025_WBUF_DEFINES
`ifndef MACRO_CACHE_LINE_OFF_ADDR_W
`define MACRO_CACHE_LINE_OFF_ADDR_W 4
`endif
`ifndef AXI_ADDR_SIZE_4
`define AXI_ADDR_SIZE_4 3'b010
`endif
`ifndef AXI_W_STRB_32
`define AXI_W_STRB_32 4'b1111
`endif
`define WBUF_TYPE_LINE 3'b100
`define AXI_BURST_INCR 2'b01
`endif

package ysyx_23060025_wbuf_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_AW   = 2'd1;
   localparam logic [1:0] S_W    = 2'd2;
   localparam logic [1:0] S_B    = 2'd3;
endpackage

// File: rtl/ysyx_23060025_wbuf.sv
// Single-entry dcache write buffer: captures a line writeback or uncached store in one cycle
// and drains it as one AXI4 write (AW, W beats low word first, B); in_pwrdy means empty.
module ysyx_23060025_wbuf
   import ysyx_23060025_wbuf_pkg::*;
#(
   parameter int         ADDR_WIDTH            = 32,
   parameter int         DATA_WIDTH            = 32,
   parameter int         CACHE_LINE_OFF_ADDR_W = `MACRO_CACHE_LINE_OFF_ADDR_W,
   parameter logic [3:0] AXI_ID                = 4'd0
) (
   input  logic                                     clock,
   input  logic                                     reset,
   input  logic                                     in_pwr_req,
   input  logic [ADDR_WIDTH-1:0]                    in_pwaddr,
   input  logic [8*(2**CACHE_LINE_OFF_ADDR_W)-1:0]  in_pwdata,
   input  logic [3:0]                               in_pwstrb,
   input  logic [2:0]                               in_pwtype,
   output logic                                     in_pwrdy,
   output logic                                     out_awvalid,
   input  logic                                     out_awready,
   output logic [ADDR_WIDTH-1:0]                    out_awaddr,
   output logic [3:0]                               out_awid,
   output logic [7:0]                               out_awlen,
   output logic [2:0]                               out_awsize,
   output logic [1:0]                               out_awburst,
   output logic                                     out_wvalid,
   input  logic                                     out_wready,
   output logic [DATA_WIDTH-1:0]                    out_wdata,
   output logic [3:0]                               out_wstrb,
   output logic                                     out_wlast,
   input  logic                                     out_bvalid,
   output logic                                     out_bready,
   input  logic [1:0]                               out_bresp,
   output logic                                     out_werr
);
   localparam int CACHE_LINE_W = 8 * (2 ** CACHE_LINE_OFF_ADDR_W);
   localparam int BEATS        = CACHE_LINE_W / DATA_WIDTH;

   logic [1:0]              r_state;
   logic [7:0]              r_cnt;
   logic                    r_werr;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [CACHE_LINE_W-1:0] r_data;
   logic [3:0]              r_strb;
   logic [1:0]              r_size;
   logic                    r_is_line;

   logic w_aw_hs;
   logic w_w_hs;
   logic w_b_hs;
   logic w_last;

   assign w_aw_hs = (r_state == S_AW) && out_awready;
   assign w_w_hs  = (r_state == S_W) && out_wready;
   assign w_b_hs  = (r_state == S_B) && out_bvalid;
   assign w_last  = (r_cnt == out_awlen);

   assign in_pwrdy    = (r_state == S_IDLE);
   assign out_awvalid = (r_state == S_AW);
   assign out_awaddr  = r_addr;
   assign out_awid    = AXI_ID;
   assign out_awlen   = r_is_line ? 8'(BEATS - 1) : 8'd0;
   assign out_awsize  = r_is_line ? `AXI_ADDR_SIZE_4 : {1'b0, r_size};
   assign out_awburst = `AXI_BURST_INCR;
   assign out_wvalid  = (r_state == S_W);
   assign out_wdata   = r_data[DATA_WIDTH-1:0];
   assign out_wstrb   = r_is_line ? `AXI_W_STRB_32 : r_strb;
   assign out_wlast   = w_last;
   assign out_bready  = (r_state == S_B);
   assign out_werr    = r_werr;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_werr  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (in_pwr_req) r_state <= S_AW;
            S_AW: begin
               if (w_aw_hs) begin
                  r_state <= S_W;
                  r_cnt   <= 8'd0;
               end
            end
            S_W: begin
               if (w_w_hs) begin
                  if (w_last) r_state <= S_B;
                  else        r_cnt   <= r_cnt + 8'd1;
               end
            end
            default: begin
               if (w_b_hs) begin
                  r_state <= S_IDLE;
                  if (out_bresp != 2'b00) r_werr <= 1'b1;
               end
            end
         endcase
      end
   end

   // Entry registers need no reset: they are only observed behind a valid.
   always_ff @(posedge clock) begin
      if (in_pwrdy && in_pwr_req) begin
         r_addr    <= in_pwaddr;
         r_data    <= in_pwdata;
         r_strb    <= in_pwstrb;
         r_size    <= in_pwtype[1:0];
         r_is_line <= (in_pwtype == `WBUF_TYPE_LINE);
      end else if (w_w_hs) begin
         r_data <= r_data >> DATA_WIDTH;
      end
   end

   a_no_req_when_busy: assert property (@(posedge clock) disable iff (reset)
      !(in_pwr_req && (r_state != S_IDLE)));
endmodule

// File: tb/tb_ysyx_23060025_wbuf.sv
// Directed and randomized checks of the write buffer against a transaction-level model.
module tb_ysyx_23060025_wbuf;
   localparam int OFF   = 4;
   localparam int LW    = 8 * (2 ** OFF);
   localparam int BEATS = LW / 32;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_pwr_req = 1'b0;
   logic [31:0]   in_pwaddr = '0;
   logic [LW-1:0] in_pwdata = '0;
   logic [3:0]    in_pwstrb = '0;
   logic [2:0]    in_pwtype = '0;
   logic          in_pwrdy;
   logic          out_awvalid, out_awready = 1'b0;
   logic [31:0]   out_awaddr;
   logic [3:0]    out_awid;
   logic [7:0]    out_awlen;
   logic [2:0]    out_awsize;
   logic [1:0]    out_awburst;
   logic          out_wvalid, out_wready = 1'b0;
   logic [31:0]   out_wdata;
   logic [3:0]    out_wstrb;
   logic          out_wlast;
   logic          out_bvalid = 1'b0, out_bready;
   logic [1:0]    out_bresp = 2'b00;
   logic          out_werr;

   ysyx_23060025_wbuf #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .CACHE_LINE_OFF_ADDR_W(OFF), .AXI_ID(4'd0)
   ) dut (
      .clock(clock), .reset(reset),
      .in_pwr_req(in_pwr_req), .in_pwaddr(in_pwaddr), .in_pwdata(in_pwdata),
      .in_pwstrb(in_pwstrb), .in_pwtype(in_pwtype), .in_pwrdy(in_pwrdy),
      .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awaddr(out_awaddr),
      .out_awid(out_awid), .out_awlen(out_awlen), .out_awsize(out_awsize),
      .out_awburst(out_awburst),
      .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata),
      .out_wstrb(out_wstrb), .out_wlast(out_wlast),
      .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bresp(out_bresp),
      .out_werr(out_werr)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   // slave behaviour knobs and state
   int       aw_delay = 0;
   int       aw_wait = 0;
   bit       w_toggle = 1'b0;
   bit       w_ph = 1'b1;
   bit       b_pend = 1'b0;
   logic [1:0] b_resp_val = 2'b00;
   bit       aw_hold = 1'b0;
   logic [31:0] h_addr;
   logic [7:0]  h_len;
   logic [2:0]  h_size;

   // transaction log
   int          aw_cnt = 0;
   int          b_cnt = 0;
   logic [31:0] l_addr;
   logic [7:0]  l_len;
   logic [2:0]  l_size;
   logic [1:0]  l_burst;
   logic [3:0]  l_id;
   logic [31:0] wdata_q[$];
   logic [3:0]  wstrb_q[$];
   logic        wlast_q[$];
   logic        werr_exp = 1'b0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then act as the AXI slave for the new cycle and log handshakes.
   task automatic cycle();
      @(posedge clock);
      #1;
      out_awready = (out_awvalid === 1'b1) && (aw_wait >= aw_delay);
      out_wready  = w_toggle ? w_ph : 1'b1;
      w_ph        = ~w_ph;
      out_bvalid  = b_pend;
      out_bresp   = b_pend ? b_resp_val : 2'b00;
      if (out_awvalid === 1'b1) begin
         if (aw_hold) begin
            chk("aw_addr_stable", out_awaddr, h_addr);
            chk("aw_len_stable", out_awlen, h_len);
            chk("aw_size_stable", out_awsize, h_size);
         end
         h_addr = out_awaddr; h_len = out_awlen; h_size = out_awsize;
         if (out_awready) begin
            aw_cnt++;
            l_addr = out_awaddr; l_len = out_awlen; l_size = out_awsize;
            l_burst = out_awburst; l_id = out_awid;
            aw_hold = 1'b0;
            aw_wait = 0;
         end else begin
            aw_hold = 1'b1;
            aw_wait++;
         end
      end else begin
         aw_hold = 1'b0;
      end
      if (out_wvalid === 1'b1 && out_wready) begin
         wdata_q.push_back(out_wdata);
         wstrb_q.push_back(out_wstrb);
         wlast_q.push_back(out_wlast);
         if (out_wlast === 1'b1) b_pend = 1'b1;
      end
      if (out_bvalid && out_bready === 1'b1) begin
         b_pend = 1'b0;
         b_cnt++;
      end
   endtask

   task automatic clear_log();
      aw_cnt = 0; b_cnt = 0; aw_wait = 0;
      wdata_q.delete(); wstrb_q.delete(); wlast_q.delete();
   endtask

   // Issue one request when empty, run it to completion, compare against the expected transaction.
   task automatic run_txn(input logic [2:0] t, input logic [31:0] a, input logic [LW-1:0] d,
                          input logic [3:0] s, output int lat, output int waited);
      int nb;
      logic is_line;
      is_line = (t == 3'b100);
      nb = is_line ? BEATS : 1;
      clear_log();
      waited = 0;
      while (in_pwrdy !== 1'b1 && waited < 100) begin
         cycle();
         waited++;
      end
      chk("pwrdy_before_req", in_pwrdy, 1'b1);
      in_pwr_req = 1'b1; in_pwaddr = a; in_pwdata = d; in_pwstrb = s; in_pwtype = t;
      cycle();
      in_pwr_req = 1'b0;
      chk("awvalid_after_req", out_awvalid, 1'b1);
      lat = 1;
      while (in_pwrdy !== 1'b1 && lat < 300) begin
         cycle();
         lat++;
      end
      chk("txn_completes", in_pwrdy, 1'b1);
      if (b_resp_val != 2'b00) werr_exp = 1'b1;
      chk("aw_count", aw_cnt, 1);
      chk("awaddr", l_addr, a);
      chk("awlen", l_len, 8'(nb - 1));
      chk("awsize", l_size, is_line ? 3'd2 : {1'b0, t[1:0]});
      chk("awburst", l_burst, 2'b01);
      chk("awid", l_id, 4'd0);
      chk("beat_count", wdata_q.size(), nb);
      for (int i = 0; i < nb && i < wdata_q.size(); i++) begin
         chk("wdata", wdata_q[i], d[32*i +: 32]);
         chk("wstrb", wstrb_q[i], is_line ? 4'hF : s);
         chk("wlast", wlast_q[i], (i == nb - 1));
      end
      chk("b_count", b_cnt, 1);
      chk("werr", out_werr, werr_exp);
   endtask

   initial begin
      int lat, waited, k, idx;
      logic [2:0]    t;
      logic [31:0]   a;
      logic [LW-1:0] d;
      logic [3:0]    s;

      // reset state
      reset = 1'b1;
      repeat (3) cycle();
      chk("rst_awvalid", out_awvalid, 1'b0);
      chk("rst_wvalid", out_wvalid, 1'b0);
      chk("rst_bready", out_bready, 1'b0);
      chk("rst_pwrdy", in_pwrdy, 1'b1);
      chk("rst_werr", out_werr, 1'b0);
      reset = 1'b0;
      cycle();

      // full line, all ready: request-to-empty of 3+BEATS cycles
      run_txn(3'b100, 32'h8000_0010, {32'h4, 32'h3, 32'h2, 32'h1}, 4'h0, lat, waited);
      chk("line_latency", lat, 3 + BEATS);

      // single byte store
      run_txn(3'b000, 32'h1000_0003, {96'h0, 32'hAB00_0000}, 4'b1000, lat, waited);
      chk("byte_latency", lat, 4);

      // backpressure on AW and W
      aw_delay = 5; w_toggle = 1'b1;
      d = {$urandom, $urandom, $urandom, $urandom};
      run_txn(3'b100, 32'h8000_1240, d, 4'h0, lat, waited);
      run_txn(3'b001, 32'h1000_0102, {96'h0, $urandom}, 4'b1100, lat, waited);
      aw_delay = 0; w_toggle = 1'b0;

      // error response is sticky across a later OKAY
      b_resp_val = 2'b10;
      run_txn(3'b010, 32'h1000_0200, {96'h0, 32'hDEAD_BEEF}, 4'hF, lat, waited);
      b_resp_val = 2'b00;
      run_txn(3'b010, 32'h1000_0204, {96'h0, 32'h1234_5678}, 4'hF, lat, waited);

      // reset in the middle of a burst
      clear_log();
      in_pwr_req = 1'b1; in_pwaddr = 32'h8000_0400; in_pwtype = 3'b100;
      in_pwdata = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      in_pwr_req = 1'b0;
      k = 0;
      while (wdata_q.size() < 2 && k < 50) begin
         cycle();
         k++;
      end
      chk("two_beats_before_reset", wdata_q.size() >= 2, 1'b1);
      cycle();
      reset = 1'b1;
      cycle();
      chk("midrst_wvalid", out_wvalid, 1'b0);
      chk("midrst_awvalid", out_awvalid, 1'b0);
      chk("midrst_pwrdy", in_pwrdy, 1'b1);
      chk("midrst_werr", out_werr, 1'b0);
      reset = 1'b0;
      b_pend = 1'b0; aw_hold = 1'b0; werr_exp = 1'b0;
      out_bvalid = 1'b0; out_awready = 1'b0;
      cycle();
      run_txn(3'b100, 32'h8000_0400, {32'h44, 32'h33, 32'h22, 32'h11}, 4'h0, lat, waited);

      // back-to-back: second request in the very cycle pwrdy rises
      run_txn(3'b100, 32'h8000_0800, {$urandom, $urandom, $urandom, $urandom}, 4'h0, lat, waited);
      run_txn(3'b100, 32'h8000_0810, {$urandom, $urandom, $urandom, $urandom}, 4'h0, lat, waited);
      chk("b2b_no_wait", waited, 0);
      chk("b2b_latency", lat, 3 + BEATS);

      // randomized mix
      for (int n = 0; n < 12; n++) begin
         idx = $urandom_range(0, 3);
         t = (idx == 3) ? 3'b100 : 3'(idx);
         a = $urandom;
         if (t == 3'b100) a[3:0] = 4'h0;
         d = {$urandom, $urandom, $urandom, $urandom};
         s = 4'($urandom_range(1, 15));
         aw_delay = $urandom_range(0, 3);
         w_toggle = 1'($urandom_range(0, 1));
         b_resp_val = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
         run_txn(t, a, d, s, lat, waited);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
